// File: rtl/ahb3lite_pkg.sv
// Shared types and defaults for the AHB3-Lite memory write-port arbiter.
package ahb3lite_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_t;

   localparam int DEF_AW = 32;
   localparam int DEF_DW = 32;

endpackage

// File: rtl/ahb3lite_rr_arb2.sv
// Two-way round-robin pick: one-hot winner from req[1:0], ties broken by rr_ptr.
module ahb3lite_rr_arb2 (
   input  logic [1:0] req,
   input  logic       rr_ptr,
   output logic [1:0] pick
);

   always_comb begin
      pick = req;
      if (req == 2'b11) begin
         pick = rr_ptr ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/ahb3lite_mem_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the ahb3lite_memory write port (CPU vs DMA).
// Optional beat-limit preemption is enabled with `define ARB_BURST_LIMIT_EN.
//
//   state   | meaning
//   --------+---------------------------------------------
//   ST_IDLE | port free, arbitrate pending requests
//   ST_OWN0 | requester 0 (CPU) owns the port until its burst ends
//   ST_OWN1 | requester 1 (DMA) owns the port until its burst ends
module ahb3lite_mem_wr_arbiter
   import ahb3lite_pkg::*;
#(
   parameter int AW        = DEF_AW,
   parameter int DW        = DEF_DW,
   parameter int MAX_BEATS = 16
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   input  logic          last0,
   output logic          gnt0,
   input  logic          req1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   input  logic          last1,
   output logic          gnt1,
   output logic [AW-1:0] mem_WR_addr,
   output logic          mem_write_flag,
   output logic [DW-1:0] HWDATA_toMem,
   output logic          busy
);

   arb_state_t    state_q, state_d;
   logic          rr_ptr_q, rr_ptr_d;
   logic          wr_flag_q, wr_flag_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;

   logic [1:0]    pick;
   logic          beat0, beat1;
   logic          pre0, pre1;
   logic          end0, end1;

   assign beat0 = req0 & (state_q == ST_OWN0);
   assign beat1 = req1 & (state_q == ST_OWN1);

   ahb3lite_rr_arb2 u_rr_arb2 (
      .req    ({req1, req0}),
      .rr_ptr (rr_ptr_q),
      .pick   (pick)
   );

`ifdef ARB_BURST_LIMIT_EN
   localparam int CW = $clog2(MAX_BEATS + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          limit_hit;

   // This beat is the MAX_BEATS-th (or later, once saturated) of the current ownership.
   assign limit_hit = (cnt_q >= CW'(MAX_BEATS - 1));
   assign pre0      = limit_hit & req1;
   assign pre1      = limit_hit & req0;

   always_comb begin
      cnt_d = cnt_q;
      if ((state_d != state_q) && (state_d != ST_IDLE)) begin
         cnt_d = '0;
      end else if (beat0 | beat1) begin
         cnt_d = (cnt_q == CW'(MAX_BEATS)) ? cnt_q : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   localparam int unused_max_beats = MAX_BEATS;

   assign pre0 = 1'b0;
   assign pre1 = 1'b0;
`endif

   assign end0 = beat0 & (last0 | pre0);
   assign end1 = beat1 & (last1 | pre1);

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      wr_flag_d = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;

      case (state_q)
         ST_IDLE: begin
            if (pick[0]) begin
               state_d = ST_OWN0;
            end else if (pick[1]) begin
               state_d = ST_OWN1;
            end
         end
         ST_OWN0: begin
            if (end0) begin
               rr_ptr_d = 1'b1;
               state_d  = req1 ? ST_OWN1 : ST_IDLE;
            end
         end
         ST_OWN1: begin
            if (end1) begin
               rr_ptr_d = 1'b0;
               state_d  = req0 ? ST_OWN0 : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (beat0) begin
         wr_flag_d = 1'b1;
         addr_d    = addr0;
         data_d    = wdata0;
      end else if (beat1) begin
         wr_flag_d = 1'b1;
         addr_d    = addr1;
         data_d    = wdata1;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= 1'b0;
         wr_flag_q <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         wr_flag_q <= wr_flag_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
      end
   end

   assign gnt0           = (state_q == ST_OWN0);
   assign gnt1           = (state_q == ST_OWN1);
   assign busy           = (state_q != ST_IDLE);
   assign mem_write_flag = wr_flag_q;
   assign mem_WR_addr    = addr_q;
   assign HWDATA_toMem   = data_q;

endmodule

// File: tb/tb_ahb3lite_mem_wr_arbiter.sv
// Directed bench for ahb3lite_mem_wr_arbiter; burst-limit case runs when ARB_BURST_LIMIT_EN is defined.
module tb_ahb3lite_mem_wr_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [31:0] K0 = 32'hC0DE0000;
   localparam logic [31:0] K1 = 32'hBEEF0000;

   logic          HCLK;
   logic          HRESETn;
   logic          req0, last0, gnt0;
   logic          req1, last1, gnt1;
   logic [AW-1:0] addr0, addr1, mem_WR_addr;
   logic [DW-1:0] wdata0, wdata1, HWDATA_toMem;
   logic          mem_write_flag, busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];

   ahb3lite_mem_wr_arbiter #(.AW(AW), .DW(DW), .MAX_BEATS(4)) dut (
      .HCLK           (HCLK),
      .HRESETn        (HRESETn),
      .req0           (req0),
      .addr0          (addr0),
      .wdata0         (wdata0),
      .last0          (last0),
      .gnt0           (gnt0),
      .req1           (req1),
      .addr1          (addr1),
      .wdata1         (wdata1),
      .last1          (last1),
      .gnt1           (gnt1),
      .mem_WR_addr    (mem_WR_addr),
      .mem_write_flag (mem_write_flag),
      .HWDATA_toMem   (HWDATA_toMem),
      .busy           (busy)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle_inputs();
      req0 = 0; addr0 = '0; wdata0 = '0; last0 = 0;
      req1 = 0; addr1 = '0; wdata1 = '0; last1 = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      HRESETn = 0;
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      HRESETn = 1;
   endtask

   // Both requesters present consecutive beats at base+4*idx; each advances only when its beat was accepted.
   task automatic run_traffic(input int n0, input int len0, input logic [31:0] base0,
                              input int n1, input int len1, input logic [31:0] base1,
                              input string tag);
      int  idx0 = 0;
      int  idx1 = 0;
      int  wr_cnt = 0;
      int  cyc = 0;
      logic b0, b1;
      req0 = (idx0 < n0); addr0 = base0 + 32'(4 * idx0); wdata0 = addr0 ^ K0; last0 = ((idx0 % len0) == len0 - 1);
      req1 = (idx1 < n1); addr1 = base1 + 32'(4 * idx1); wdata1 = addr1 ^ K1; last1 = ((idx1 % len1) == len1 - 1);
      while ((cyc < 100) && (wr_cnt < exp_addr.size())) begin
         b0 = req0 & gnt0;
         b1 = req1 & gnt1;
         tick();
         cyc++;
         if (mem_write_flag) begin
            chk({tag, "_addr"}, mem_WR_addr, exp_addr[wr_cnt]);
            chk({tag, "_data"}, HWDATA_toMem, exp_data[wr_cnt]);
            wr_cnt++;
         end
         if (b0) begin
            idx0++;
            req0 = (idx0 < n0); addr0 = base0 + 32'(4 * idx0); wdata0 = addr0 ^ K0;
            last0 = ((idx0 % len0) == len0 - 1);
         end
         if (b1) begin
            idx1++;
            req1 = (idx1 < n1); addr1 = base1 + 32'(4 * idx1); wdata1 = addr1 ^ K1;
            last1 = ((idx1 % len1) == len1 - 1);
         end
      end
      chk({tag, "_wr_count"}, 32'(wr_cnt), 32'(exp_addr.size()));
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
      idle_inputs();
   endtask

   task automatic push_exp(input logic [31:0] a, input logic [31:0] k);
      exp_addr.push_back(a);
      exp_data.push_back(a ^ k);
   endtask

   initial begin
      HRESETn = 0;
      idle_inputs();
      #2;
      chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
      chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
      chk("rst_flag", {31'd0, mem_write_flag}, 32'd0);
      chk("rst_addr", mem_WR_addr, 32'd0);
      chk("rst_data", HWDATA_toMem, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      do_reset();

      // Single beat from requester 0
      req0 = 1; addr0 = 32'h10; wdata0 = 32'hA5A5A5A5; last0 = 1;
      tick();
      chk("single_gnt0", {31'd0, gnt0}, 32'd1);
      chk("single_flag_pre", {31'd0, mem_write_flag}, 32'd0);
      tick();
      chk("single_flag", {31'd0, mem_write_flag}, 32'd1);
      chk("single_addr", mem_WR_addr, 32'h10);
      chk("single_data", HWDATA_toMem, 32'hA5A5A5A5);
      chk("single_idle", {31'd0, busy}, 32'd0);
      req0 = 0;
      tick();
      chk("single_flag_off", {31'd0, mem_write_flag}, 32'd0);
      chk("single_addr_hold", mem_WR_addr, 32'h10);

      // Simultaneous requests after reset: 0 first, then direct handoff to 1
      do_reset();
      req0 = 1; addr0 = 32'h20; wdata0 = 32'h2020; last0 = 0;
      req1 = 1; addr1 = 32'h100; wdata1 = 32'h1111; last1 = 1;
      tick();
      chk("sim_gnt0", {30'd0, gnt1, gnt0}, 32'b01);
      tick();
      chk("sim_b0_addr", mem_WR_addr, 32'h20);
      chk("sim_b0_gnt", {30'd0, gnt1, gnt0}, 32'b01);
      addr0 = 32'h24; wdata0 = 32'h2424; last0 = 1;
      tick();
      chk("sim_b1_addr", mem_WR_addr, 32'h24);
      chk("sim_handoff", {30'd0, gnt1, gnt0}, 32'b10);
      chk("sim_handoff_busy", {31'd0, busy}, 32'd1);
      req0 = 0;
      tick();
      chk("sim_r1_addr", mem_WR_addr, 32'h100);
      chk("sim_r1_data", HWDATA_toMem, 32'h1111);
      chk("sim_r1_idle", {30'd0, gnt1, gnt0}, 32'b00);
      req1 = 0;

      // Burst lock: requester 1 pauses mid-burst while requester 0 waits
      req1 = 1; addr1 = 32'h200; wdata1 = 32'h2222; last1 = 0;
      tick();
      chk("lock_gnt1", {30'd0, gnt1, gnt0}, 32'b10);
      tick();
      chk("lock_b0_addr", mem_WR_addr, 32'h200);
      req1 = 0;
      req0 = 1; addr0 = 32'h30; wdata0 = 32'h3030; last0 = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("lock_hold_gnt", {30'd0, gnt1, gnt0}, 32'b10);
         chk("lock_hold_flag", {31'd0, mem_write_flag}, 32'd0);
      end
      req1 = 1; addr1 = 32'h204; wdata1 = 32'h2424; last1 = 1;
      tick();
      chk("lock_b1_addr", mem_WR_addr, 32'h204);
      chk("lock_to_own0", {30'd0, gnt1, gnt0}, 32'b01);
      req1 = 0;
      tick();
      chk("lock_r0_addr", mem_WR_addr, 32'h30);
      chk("lock_r0_flag", {31'd0, mem_write_flag}, 32'd1);
      req0 = 0;

      // Round-robin: two 4-beat-burst streams alternate 0,1,0,1
      do_reset();
      exp_addr.delete(); exp_data.delete();
      for (int b = 0; b < 4; b++) begin
         for (int j = 0; j < 4; j++) begin
            if (b % 2 == 0) push_exp(32'h1000 + 32'(4 * ((b / 2) * 4 + j)), K0);
            else            push_exp(32'h2000 + 32'(4 * ((b / 2) * 4 + j)), K1);
         end
      end
      run_traffic(8, 4, 32'h1000, 8, 4, 32'h2000, "rr");

      // Reset asserted while beat 2 of 4 is being accepted
      req0 = 1; addr0 = 32'h3000; wdata0 = 32'h3000; last0 = 0;
      tick();
      chk("rstmid_gnt0", {31'd0, gnt0}, 32'd1);
      tick();
      chk("rstmid_b0", mem_WR_addr, 32'h3000);
      addr0 = 32'h3004; wdata0 = 32'h3004;
      tick();
      chk("rstmid_b1", mem_WR_addr, 32'h3004);
      addr0 = 32'h3008; wdata0 = 32'h3008;
      #2;
      HRESETn = 0;
      #1;
      chk("rstmid_gnt_async", {30'd0, gnt1, gnt0}, 32'b00);
      chk("rstmid_flag_async", {31'd0, mem_write_flag}, 32'd0);
      chk("rstmid_busy_async", {31'd0, busy}, 32'd0);
      tick();
      chk("rstmid_no_write", {31'd0, mem_write_flag}, 32'd0);
      chk("rstmid_addr", mem_WR_addr, 32'd0);
      req0 = 0;
      @(negedge HCLK);
      HRESETn = 1;
      tick();
      chk("rstmid_idle", {31'd0, busy}, 32'd0);

`ifdef ARB_BURST_LIMIT_EN
      // Beat limit 4: 10-beat burst from 0 is preempted by pending 1, then resumes
      do_reset();
      exp_addr.delete(); exp_data.delete();
      for (int i = 0; i < 4; i++) push_exp(32'h4000 + 32'(4 * i), K0);
      push_exp(32'h5000, K1);
      for (int i = 4; i < 10; i++) push_exp(32'h4000 + 32'(4 * i), K0);
      run_traffic(10, 10, 32'h4000, 1, 1, 32'h5000, "limit");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
